// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath leaves.
//   ALU_WIDTH : default operand/result width of the ALU datapath
//   flags_t   : per-result status flags {carry, ovf, zero}
//               carry holds carry-out for additions and borrow for
//               subtractions, so the flag register downstream can treat
//               both results uniformly.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } flags_t;

endpackage : alu_pkg

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// Plain WIDTH-bit ripple-carry adder built from per-bit full-adder logic.
// Purely combinational.
// Ports:
//   a, b  : WIDTH-bit addends
//   cin   : carry into bit 0
//   s     : WIDTH-bit sum (a + b + cin truncated)
//   cout  : carry out of the MSB
// ---------------------------------------------------------------------------
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  // The carry is walked bit by bit through a local variable rather than a
  // carry vector; this keeps the ripple chain explicit while avoiding a
  // self-referencing net that some tools flag as a combinational loop.
  always_comb begin
    logic w_carry;
    s       = '0;
    w_carry = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]    = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    cout = w_carry;
  end

endmodule : ripple_carry_adder

// File: rtl/adder_subtractor.sv
// ---------------------------------------------------------------------------
// adder_subtractor
// Registered two's-complement add/subtract unit. A+B and A-B are computed in
// parallel from the same operand pair and registered together with their
// carry/borrow, signed-overflow and zero flags. Latency is one cycle and a
// new operand pair may be accepted every cycle.
// WIDTH is intended for the range 2..32.
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-high reset, clears every output
//   in_valid   : a/b are valid and are captured this cycle
//   a, b       : signed operands
//   out_valid  : results valid (one cycle after in_valid)
//   sum        : A+B truncated to WIDTH
//   cout_add   : unsigned carry out of A+B
//   ovf_add    : signed overflow of A+B
//   diff       : A-B truncated to WIDTH
//   cout_sub   : borrow of A-B (1 when A < B unsigned)
//   ovf_sub    : signed overflow of A-B
//   zero_sum   : sum == 0
//   zero_diff  : diff == 0
// ---------------------------------------------------------------------------
module adder_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout_add,
  output logic             ovf_add,
  output logic [WIDTH-1:0] diff,
  output logic             cout_sub,
  output logic             ovf_sub,
  output logic             zero_sum,
  output logic             zero_diff
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_bInv;
  logic             w_addCout;
  logic             w_subCout;
  flags_t           w_addFlags;
  flags_t           w_subFlags;

  logic             r_outValid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_diff;
  flags_t           r_addFlags;
  flags_t           r_subFlags;

  assign w_bInv = ~b;

  // Addition path: plain A + B.
  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_addPath (
    .a    (a),
    .b    (b),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_addCout)
  );

  // Subtraction path: A + ~B + 1 on an identical ripple structure.
  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_subPath (
    .a    (a),
    .b    (w_bInv),
    .cin  (1'b1),
    .s    (w_diff),
    .cout (w_subCout)
  );

  // Flag derivation. For subtraction the raw carry is 1 when no borrow
  // occurred, so it is inverted to present a borrow. Overflow on subtract
  // is only possible when the operand signs differ, since A-B behaves like
  // A plus an operand of the opposite sign.
  always_comb begin
    w_addFlags.carry = w_addCout;
    w_addFlags.ovf   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
    w_addFlags.zero  = (w_sum == '0);
    w_subFlags.carry = ~w_subCout;
    w_subFlags.ovf   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
    w_subFlags.zero  = (w_diff == '0);
  end

  // Output register. Reset wins over in_valid so an operation presented
  // during reset is dropped. When in_valid is low only out_valid falls and
  // the previous results stay visible for the flag register downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_sum      <= '0;
      r_diff     <= '0;
      r_addFlags <= '0;
      r_subFlags <= '0;
    end else begin
      r_outValid <= in_valid;
      if (in_valid) begin
        r_sum      <= w_sum;
        r_diff     <= w_diff;
        r_addFlags <= w_addFlags;
        r_subFlags <= w_subFlags;
      end
    end
  end

  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout_add  = r_addFlags.carry;
  assign ovf_add   = r_addFlags.ovf;
  assign zero_sum  = r_addFlags.zero;
  assign diff      = r_diff;
  assign cout_sub  = r_subFlags.carry;
  assign ovf_sub   = r_subFlags.ovf;
  assign zero_diff = r_subFlags.zero;

endmodule : adder_subtractor

// File: tb/tb_adder_subtractor.sv
// ---------------------------------------------------------------------------
// tb_adder_subtractor
// Self-checking bench for adder_subtractor (WIDTH = 8). Stimulus pushes the
// expected response, computed with plain integer arithmetic, into a queue;
// a monitor on the falling edge pops and compares whenever out_valid is
// high, and checks that results hold while out_valid is low.
// ---------------------------------------------------------------------------
module tb_adder_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         coutAdd;
    logic         ovfAdd;
    logic [W-1:0] diff;
    logic         coutSub;
    logic         ovfSub;
    logic         zeroSum;
    logic         zeroDiff;
  } expect_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         outValid;
  logic [W-1:0] sum;
  logic         coutAdd;
  logic         ovfAdd;
  logic [W-1:0] diff;
  logic         coutSub;
  logic         ovfSub;
  logic         zeroSum;
  logic         zeroDiff;

  int      assertCount = 0;
  int      failCount   = 0;
  expect_t expQ[$];
  expect_t held;
  logic    expValid    = 1'b0;
  logic    armed       = 1'b0;

  adder_subtractor #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .a         (a),
    .b         (b),
    .out_valid (outValid),
    .sum       (sum),
    .cout_add  (coutAdd),
    .ovf_add   (ovfAdd),
    .diff      (diff),
    .cout_sub  (coutSub),
    .ovf_sub   (ovfSub),
    .zero_sum  (zeroSum),
    .zero_diff (zeroDiff)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: arithmetic on integers, wrapping and flags taken from
  // the numeric meaning of each result rather than from any bit structure.
  function automatic expect_t model(input logic [W-1:0] opA, input logic [W-1:0] opB);
    expect_t e;
    int ua;
    int ub;
    int sa;
    int sb;
    int us;
    int ss;
    int sd;
    int ud;
    ua = int'(opA);
    ub = int'(opB);
    sa = int'($signed(opA));
    sb = int'($signed(opB));
    us = ua + ub;
    ss = sa + sb;
    sd = sa - sb;
    ud = (ua - ub + (1 << W)) % (1 << W);
    e.sum      = W'(us % (1 << W));
    e.coutAdd  = (us >= (1 << W));
    e.ovfAdd   = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    e.diff     = W'(ud);
    e.coutSub  = (ua < ub);
    e.ovfSub   = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    e.zeroSum  = (us % (1 << W)) == 0;
    e.zeroDiff = (ud == 0);
    return e;
  endfunction

  function automatic expect_t zeroExpect();
    expect_t e;
    e.sum = '0; e.coutAdd = 0; e.ovfAdd = 0; e.diff = '0;
    e.coutSub = 0; e.ovfSub = 0; e.zeroSum = 0; e.zeroDiff = 0;
    return e;
  endfunction

  // Compare one observed value with its expectation and count it.
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input expect_t e);
    checkOutput({tag, ".sum"},       sum,             e.sum);
    checkOutput({tag, ".cout_add"},  W'(coutAdd),     W'(e.coutAdd));
    checkOutput({tag, ".ovf_add"},   W'(ovfAdd),      W'(e.ovfAdd));
    checkOutput({tag, ".diff"},      diff,            e.diff);
    checkOutput({tag, ".cout_sub"},  W'(coutSub),     W'(e.coutSub));
    checkOutput({tag, ".ovf_sub"},   W'(ovfSub),      W'(e.ovfSub));
    checkOutput({tag, ".zero_sum"},  W'(zeroSum),     W'(e.zeroSum));
    checkOutput({tag, ".zero_diff"}, W'(zeroDiff),    W'(e.zeroDiff));
  endtask

  // Scoreboard producer: on each rising edge record what the DUT should
  // present next cycle. Reset discards anything in flight.
  always @(posedge clk) begin
    armed <= 1'b1;
    if (rst) begin
      expQ.delete();
      held     = zeroExpect();
      expValid = 1'b0;
    end else begin
      expValid = inValid;
      if (inValid) expQ.push_back(model(a, b));
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      checkOutput("out_valid", W'(outValid), W'(expValid));
      if (outValid) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL scoreboard at %0t: out_valid=1 with no expected result queued", $time);
        end else begin
          held = expQ.pop_front();
          checkAll("result", held);
        end
      end else begin
        checkAll("hold", held);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] opA, input logic [W-1:0] opB);
    rst     = r;
    inValid = v;
    a       = opA;
    b       = opB;
    @(posedge clk);
    #1;
  endtask

  initial begin
    held = zeroExpect();
    rst = 1'b1; inValid = 1'b0; a = '0; b = '0;
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h55, 8'h33);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    // Directed cases including overflow and borrow boundaries.
    applyStimulus(1'b0, 1'b1, 8'd15,  8'd10);
    applyStimulus(1'b0, 1'b1, 8'd127, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'd10,  8'd20);
    applyStimulus(1'b0, 1'b1, 8'd50,  8'h9C);
    applyStimulus(1'b0, 1'b1, 8'd127, 8'd127);
    applyStimulus(1'b0, 1'b1, 8'hCE,  8'd30);

    // Reset pulse with an operation pending is dropped, then -128 + -128.
    applyStimulus(1'b1, 1'b1, 8'h80, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h80, 8'h80);
    applyStimulus(1'b0, 1'b0, 8'h12, 8'h34);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    // Corner pairs.
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h80, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h80);
    applyStimulus(1'b0, 1'b1, 8'h7F, 8'hFF);

    // Randomised traffic with occasional idle cycles and rare resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 3) != 0),
                    W'($urandom), W'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d results still queued, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule : tb_adder_subtractor
